// File: rtl/bk_bus_pkg.sv
// -----------------------------------------------------------------------------
// bk_bus_pkg
// Shared types and helpers for the Q-bus memory arbiter.
//   state_t   : arbiter FSM states
//   BE_*      : RAM byte-enable patterns {hi,lo}
//   byte_sel  : extracts the addressed byte of a RAM word, zero-extended
//   be_sel    : byte enables for a CPU cycle from WTBT and address bit 0
// -----------------------------------------------------------------------------
package bk_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACC_CPU = 2'd1,
    ACC_VID = 2'd2,
    RPLY    = 2'd3
  } state_t;

  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;

  // Odd byte addresses live in the high half of the RAM word.
  function automatic logic [15:0] byte_sel(input logic addr0, input logic [15:0] data);
    logic [15:0] res;
    if (addr0) begin
      res = {8'h00, data[15:8]};
    end else begin
      res = {8'h00, data[7:0]};
    end
    return res;
  endfunction

  // Word cycles touch both lanes; byte cycles touch only the addressed lane.
  function automatic logic [1:0] be_sel(input logic wtbt, input logic addr0);
    logic [1:0] res;
    if (!wtbt) begin
      res = BE_WORD;
    end else if (addr0) begin
      res = BE_HI;
    end else begin
      res = BE_LO;
    end
    return res;
  endfunction

endpackage

// File: rtl/qbus_arb_pick.sv
// -----------------------------------------------------------------------------
// qbus_arb_pick
// Grant decision between a pending CPU cycle and a video fetch, with a
// starvation counter that forces a CPU grant after STARVE_MAX consecutive
// video grants taken while the CPU was waiting.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   arb_en      : arbiter is idle and may issue a grant this cycle
//   cpu_pend    : a CPU read/write cycle is waiting
//   vid_pend    : a video fetch is waiting
//   grant_cpu   : grant the RAM to the CPU (combinational)
//   grant_vid   : grant the RAM to the video fetcher (combinational)
// STARVE_MAX must fit in 4 bits.
// -----------------------------------------------------------------------------
module qbus_arb_pick
  import bk_bus_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_en,
  input  logic cpu_pend,
  input  logic vid_pend,
  output logic grant_cpu,
  output logic grant_vid
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt_r;

  // Grant decision: video has priority unless the CPU has been starved.
  always_comb begin
    grant_cpu = 1'b0;
    grant_vid = 1'b0;
    if (arb_en) begin
      if (cpu_pend && vid_pend) begin
        if (starve_cnt_r >= STARVE_LIM) begin
          grant_cpu = 1'b1;
        end else begin
          grant_vid = 1'b1;
        end
      end else if (cpu_pend) begin
        grant_cpu = 1'b1;
      end else if (vid_pend) begin
        grant_vid = 1'b1;
      end else begin
        grant_cpu = 1'b0;
        grant_vid = 1'b0;
      end
    end else begin
      grant_cpu = 1'b0;
      grant_vid = 1'b0;
    end
  end

  // Starvation counter: counts video grants that bypassed a waiting CPU.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_r <= 4'd0;
    end else if (grant_cpu) begin
      starve_cnt_r <= 4'd0;
    end else if (grant_vid && cpu_pend) begin
      starve_cnt_r <= starve_cnt_r + 4'd1;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

endmodule

// File: rtl/qbus_mem_arbiter.sv
// -----------------------------------------------------------------------------
// qbus_mem_arbiter
// Shares one 16-bit synchronous RAM port between the VM1 CPU Q-bus cycle
// and a video-refresh word fetcher. Generates RPLY after WAIT_CYCLES+1 RAM
// access cycles and handles WTBT byte lanes.
// Ports:
//   mclk, mreset        : clock, synchronous active-high reset
//   cpu_sync_i/din/dout : Q-bus SYNC, read strobe, write strobe
//   cpu_wtbt_i          : byte cycle
//   cpu_addr_i          : byte address
//   cpu_d_i / cpu_d_o   : write data in / read data out (held between reads)
//   cpu_rply_o          : Q-bus RPLY
//   vid_req_i/addr_i    : level video request and word address
//   vid_d_o / vid_ack_o : fetched word and its one-cycle completion pulse
//   mem_ce_o/we_o/be_o  : RAM access strobe, write enable, byte enables
//   mem_addr_o/mem_d_o  : RAM word address and write data
//   mem_d_i             : RAM read data, sampled in the last access cycle
// -----------------------------------------------------------------------------
module qbus_mem_arbiter
  import bk_bus_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned STARVE_MAX  = 3
) (
  input  logic        mclk,
  input  logic        mreset,
  input  logic        cpu_sync_i,
  input  logic        cpu_din_i,
  input  logic        cpu_dout_i,
  input  logic        cpu_wtbt_i,
  input  logic [15:0] cpu_addr_i,
  input  logic [15:0] cpu_d_i,
  output logic [15:0] cpu_d_o,
  output logic        cpu_rply_o,
  input  logic        vid_req_i,
  input  logic [14:0] vid_addr_i,
  output logic [15:0] vid_d_o,
  output logic        vid_ack_o,
  output logic        mem_ce_o,
  output logic        mem_we_o,
  output logic [1:0]  mem_be_o,
  output logic [14:0] mem_addr_o,
  output logic [15:0] mem_d_o,
  input  logic [15:0] mem_d_i
);

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

  state_t     state_r;
  logic [2:0] wait_cnt_r;
  logic       is_byte_r;    // current CPU access is a WTBT byte cycle
  logic       lane_hi_r;    // byte address was odd
  logic       cpu_block_r;  // RPLY just dropped: no CPU grant this cycle

  logic arb_en_s;
  logic cpu_pend_s;
  logic vid_pend_s;
  logic grant_cpu_s;
  logic grant_vid_s;
  logic last_acc_s;

  // Request qualification; requests are only looked at while idle.
  always_comb begin
    arb_en_s   = (state_r == IDLE);
    cpu_pend_s = cpu_sync_i & (cpu_din_i | cpu_dout_i) & ~cpu_rply_o & ~cpu_block_r;
    vid_pend_s = vid_req_i;
    last_acc_s = (wait_cnt_r == 3'd0);
  end

  qbus_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk       (mclk),
    .reset     (mreset),
    .arb_en    (arb_en_s),
    .cpu_pend  (cpu_pend_s),
    .vid_pend  (vid_pend_s),
    .grant_cpu (grant_cpu_s),
    .grant_vid (grant_vid_s)
  );

  // Main FSM: grant latch, wait counting, lane steering and registered outputs.
  always_ff @(posedge mclk) begin
    if (mreset) begin
      state_r     <= IDLE;
      wait_cnt_r  <= 3'd0;
      is_byte_r   <= 1'b0;
      lane_hi_r   <= 1'b0;
      cpu_block_r <= 1'b0;
      cpu_d_o     <= 16'h0000;
      cpu_rply_o  <= 1'b0;
      vid_d_o     <= 16'h0000;
      vid_ack_o   <= 1'b0;
      mem_ce_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= 2'b00;
      mem_addr_o  <= 15'h0000;
      mem_d_o     <= 16'h0000;
    end else begin
      vid_ack_o   <= 1'b0;
      cpu_block_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_cpu_s) begin
            state_r    <= ACC_CPU;
            wait_cnt_r <= WAIT_INIT;
            is_byte_r  <= cpu_wtbt_i;
            lane_hi_r  <= cpu_addr_i[0];
            mem_ce_o   <= 1'b1;
            mem_we_o   <= cpu_dout_i;
            mem_be_o   <= be_sel(cpu_wtbt_i, cpu_addr_i[0]);
            mem_addr_o <= cpu_addr_i[15:1];
            // Byte writes replicate the low byte so either lane sees it.
            if (!cpu_dout_i) begin
              mem_d_o <= 16'h0000;
            end else if (cpu_wtbt_i) begin
              mem_d_o <= {cpu_d_i[7:0], cpu_d_i[7:0]};
            end else begin
              mem_d_o <= cpu_d_i;
            end
          end else if (grant_vid_s) begin
            state_r    <= ACC_VID;
            wait_cnt_r <= WAIT_INIT;
            mem_ce_o   <= 1'b1;
            mem_we_o   <= 1'b0;
            mem_be_o   <= BE_WORD;
            mem_addr_o <= vid_addr_i;
            mem_d_o    <= 16'h0000;
          end else begin
            state_r <= IDLE;
          end
        end

        ACC_CPU: begin
          if (last_acc_s) begin
            mem_ce_o <= 1'b0;
            mem_we_o <= 1'b0;
            mem_be_o <= 2'b00;
            // A CPU that abandoned SYNC gets no RPLY; a write still landed.
            if (cpu_sync_i) begin
              state_r    <= RPLY;
              cpu_rply_o <= 1'b1;
              if (!mem_we_o) begin
                cpu_d_o <= is_byte_r ? byte_sel(lane_hi_r, mem_d_i) : mem_d_i;
              end else begin
                cpu_d_o <= cpu_d_o;
              end
            end else begin
              state_r <= IDLE;
            end
          end else begin
            wait_cnt_r <= wait_cnt_r - 3'd1;
          end
        end

        ACC_VID: begin
          if (last_acc_s) begin
            mem_ce_o  <= 1'b0;
            mem_we_o  <= 1'b0;
            mem_be_o  <= 2'b00;
            vid_d_o   <= mem_d_i;
            vid_ack_o <= 1'b1;
            state_r   <= IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r - 3'd1;
          end
        end

        RPLY: begin
          if (!cpu_sync_i) begin
            cpu_rply_o  <= 1'b0;
            cpu_block_r <= 1'b1;
            state_r     <= IDLE;
          end else begin
            state_r <= RPLY;
          end
        end

        default: begin
          state_r    <= IDLE;
          cpu_rply_o <= 1'b0;
          mem_ce_o   <= 1'b0;
          mem_we_o   <= 1'b0;
          mem_be_o   <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qbus_mem_arbiter.sv
module tb_qbus_mem_arbiter;
  import bk_bus_pkg::*;

  typedef struct packed {
    logic        we;
    logic [1:0]  be;
    logic [14:0] addr;
    logic [15:0] d;
  } acc_t;

  logic        clk;
  logic        mreset;
  logic        cpu_sync, cpu_din, cpu_dout, cpu_wtbt;
  logic [15:0] cpu_addr, cpu_d_wr;
  logic [15:0] cpu_d_rd;
  logic        cpu_rply;
  logic        vid_req;
  logic [14:0] vid_addr;
  logic [15:0] vid_d;
  logic        vid_ack;
  logic        mem_ce, mem_we;
  logic [1:0]  mem_be;
  logic [14:0] mem_addr;
  logic [15:0] mem_d_wr;
  logic [15:0] mem_d_rd;

  logic [15:0] ram [0:32767];
  logic        pl_en;
  logic [14:0] pl_a;
  logic [15:0] pl_d;

  int checks = 0;
  int errors = 0;

  acc_t        acc_q[$];
  logic [15:0] cpu_q[$];
  logic [15:0] vid_q[$];
  logic [15:0] cur_d;

  logic prev_ce = 1'b0;
  logic prev_rply = 1'b0;
  acc_t mon_e;
  logic [15:0] mon_w;

  qbus_mem_arbiter dut (
    .mclk       (clk),
    .mreset     (mreset),
    .cpu_sync_i (cpu_sync),
    .cpu_din_i  (cpu_din),
    .cpu_dout_i (cpu_dout),
    .cpu_wtbt_i (cpu_wtbt),
    .cpu_addr_i (cpu_addr),
    .cpu_d_i    (cpu_d_wr),
    .cpu_d_o    (cpu_d_rd),
    .cpu_rply_o (cpu_rply),
    .vid_req_i  (vid_req),
    .vid_addr_i (vid_addr),
    .vid_d_o    (vid_d),
    .vid_ack_o  (vid_ack),
    .mem_ce_o   (mem_ce),
    .mem_we_o   (mem_we),
    .mem_be_o   (mem_be),
    .mem_addr_o (mem_addr),
    .mem_d_o    (mem_d_wr),
    .mem_d_i    (mem_d_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM model with byte lanes and a backdoor preload port.
  always @(posedge clk) begin
    if (pl_en) begin
      ram[pl_a] <= pl_d;
    end else if (mem_ce) begin
      if (mem_we && mem_be[0]) ram[mem_addr][7:0]  <= mem_d_wr[7:0];
      if (mem_we && mem_be[1]) ram[mem_addr][15:8] <= mem_d_wr[15:8];
      mem_d_rd <= ram[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares each new access, RPLY and video ack.
  always @(negedge clk) begin
    if (mem_ce && !prev_ce) begin
      if (acc_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL acc_unexpected: got we=%b be=%b addr=%h", mem_we, mem_be, mem_addr);
      end else begin
        mon_e = acc_q.pop_front();
        check("acc_we",   32'(mem_we),   32'(mon_e.we));
        check("acc_be",   32'(mem_be),   32'(mon_e.be));
        check("acc_addr", 32'(mem_addr), 32'(mon_e.addr));
        check("acc_d",    32'(mem_d_wr), 32'(mon_e.d));
      end
    end
    if (cpu_rply && !prev_rply) begin
      if (cpu_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rply_unexpected: got cpu_d_o=%h", cpu_d_rd);
      end else begin
        mon_w = cpu_q.pop_front();
        check("cpu_d_o", 32'(cpu_d_rd), 32'(mon_w));
      end
    end
    if (vid_ack) begin
      if (vid_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ack_unexpected: got vid_d_o=%h", vid_d);
      end else begin
        mon_w = vid_q.pop_front();
        check("vid_d_o", 32'(vid_d), 32'(mon_w));
      end
    end
    prev_ce   <= mem_ce;
    prev_rply <= cpu_rply;
  end

  task automatic preload(input logic [14:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic push_acc(input logic we, input logic [1:0] be, input logic [14:0] a, input logic [15:0] d);
    acc_t e;
    e.we = we; e.be = be; e.addr = a; e.d = d;
    acc_q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_cpu_d"}, 32'(cpu_d_rd), 32'h0);
    check({tag, "_rply"},  32'(cpu_rply), 32'h0);
    check({tag, "_vid_d"}, 32'(vid_d),    32'h0);
    check({tag, "_ack"},   32'(vid_ack),  32'h0);
    check({tag, "_ce"},    32'(mem_ce),   32'h0);
    check({tag, "_we"},    32'(mem_we),   32'h0);
    check({tag, "_be"},    32'(mem_be),   32'h0);
    check({tag, "_addr"},  32'(mem_addr), 32'h0);
    check({tag, "_memd"},  32'(mem_d_wr), 32'h0);
  endtask

  // Full CPU cycle: strobe, wait for RPLY (bounded), release, wait for RPLY low.
  task automatic cpu_op(input logic [15:0] a, input logic wr, input logic byt,
                        input logic [15:0] d, input int exp_lat);
    int n;
    cpu_addr = a; cpu_d_wr = d; cpu_wtbt = byt;
    cpu_din = ~wr; cpu_dout = wr; cpu_sync = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!cpu_rply && n < 60);
    check("rply_seen", 32'(cpu_rply), 32'h1);
    if (exp_lat >= 0) check("rply_latency", 32'(n), 32'(exp_lat));
    cpu_sync = 1'b0; cpu_din = 1'b0; cpu_dout = 1'b0; cpu_wtbt = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (cpu_rply && n < 10);
    check("rply_drop", 32'(cpu_rply), 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    int  n;
    logic seen;
    mreset = 1'b1; pl_en = 1'b0; pl_a = 15'h0; pl_d = 16'h0;
    cpu_sync = 1'b0; cpu_din = 1'b0; cpu_dout = 1'b0; cpu_wtbt = 1'b0;
    cpu_addr = 16'h0; cpu_d_wr = 16'h0; vid_req = 1'b0; vid_addr = 15'h0;
    cur_d = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    mreset = 1'b0;
    @(posedge clk); #1;

    // Word read 0o001000 -> word 0x100
    preload(15'h0100, 16'o012345);
    preload(15'h0080, 16'h1234);
    push_acc(1'b0, 2'b11, 15'h0100, 16'h0000);
    cpu_q.push_back(16'o012345);
    cur_d = 16'o012345;
    cpu_op(16'o001000, 1'b0, 1'b0, 16'h0000, 3);

    // Byte write to odd address 0o000401: high lane only
    push_acc(1'b1, 2'b10, 15'h0080, 16'h5A5A);
    cpu_q.push_back(cur_d);
    cpu_op(16'o000401, 1'b1, 1'b1, 16'hFF5A, 3);
    check("bytewr_ram", 32'(ram[15'h0080]), 32'h5A34);

    // Byte reads from both lanes
    preload(15'h0080, 16'hA55A);
    push_acc(1'b0, 2'b10, 15'h0080, 16'h0000);
    cpu_q.push_back(16'h00A5);
    cur_d = 16'h00A5;
    cpu_op(16'o000401, 1'b0, 1'b1, 16'h0000, 3);
    push_acc(1'b0, 2'b01, 15'h0080, 16'h0000);
    cpu_q.push_back(16'h005A);
    cur_d = 16'h005A;
    cpu_op(16'o000400, 1'b0, 1'b1, 16'h0000, 3);

    // Video held against a pending CPU read: V,V,V then CPU
    preload(15'h0300, 16'hBEEF);
    preload(15'h0200, 16'hC0DE);
    repeat (3) begin
      push_acc(1'b0, 2'b11, 15'h0300, 16'h0000);
      vid_q.push_back(16'hBEEF);
    end
    push_acc(1'b0, 2'b11, 15'h0200, 16'h0000);
    cpu_q.push_back(16'hC0DE);
    cur_d = 16'hC0DE;
    vid_addr = 15'h0300; vid_req = 1'b1;
    cpu_addr = 16'h0400; cpu_wtbt = 1'b0; cpu_din = 1'b1; cpu_sync = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!cpu_rply && n < 60);
    check("starve_rply_seen", 32'(cpu_rply), 32'h1);
    check("starve_latency", 32'(n), 32'd12);
    vid_req = 1'b0;
    check("starve_cnt_clr", 32'(dut.u_pick.starve_cnt_r), 32'h0);
    cpu_sync = 1'b0; cpu_din = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (cpu_rply && n < 10);
    check("starve_rply_drop", 32'(cpu_rply), 32'h0);
    @(posedge clk); #1;

    // SYNC dropped in the middle of a word write
    push_acc(1'b1, 2'b11, 15'h0400, 16'hCAFE);
    cpu_addr = 16'h0800; cpu_d_wr = 16'hCAFE; cpu_dout = 1'b1; cpu_sync = 1'b1;
    @(posedge clk); #1;
    cpu_sync = 1'b0; cpu_dout = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (cpu_rply) seen = 1'b1;
    end
    check("drop_no_rply", 32'(seen), 32'h0);
    check("drop_ram", 32'(ram[15'h0400]), 32'hCAFE);
    check("drop_idle", 32'(dut.state_r), 32'(IDLE));
    check("drop_ce", 32'(mem_ce), 32'h0);

    // Reset during ACC_CPU, then the reissued read completes
    preload(15'h0200, 16'h1357);
    push_acc(1'b0, 2'b11, 15'h0200, 16'h0000);
    cpu_addr = 16'h0400; cpu_din = 1'b1; cpu_sync = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_in_acc", 32'(mem_ce), 32'h1);
    mreset = 1'b1; cpu_sync = 1'b0; cpu_din = 1'b0;
    @(posedge clk); #1;
    check_zero("rst_mid");
    mreset = 1'b0;
    @(posedge clk); #1;
    push_acc(1'b0, 2'b11, 15'h0200, 16'h0000);
    cpu_q.push_back(16'h1357);
    cpu_op(16'h0400, 1'b0, 1'b0, 16'h0000, 3);

    repeat (4) @(posedge clk);
    #1;
    check("acc_q_empty", 32'(acc_q.size()), 32'h0);
    check("cpu_q_empty", 32'(cpu_q.size()), 32'h0);
    check("vid_q_empty", 32'(vid_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
